branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Frontend branch predictor: bimodal 2-bit BHT plus direct-mapped BTB. Predicts each
//  decoded control-flow instruction, pushes {pc,id,bp} into the branch queue (bq_push_if
//  master side), returns the prediction to fetch, and trains at commit from bq_pop results.
//  Sits between decode and the branch FU's queue, directly upstream of it.
// PARAMETERS
//  NR_BHT_ENTRIES  64  2-bit counters, power of 2; index = pc[1 +: log2(NR_BHT_ENTRIES)]
//  NR_BTB_ENTRIES  32  BTB lines, power of 2; index = pc[1 +: log2(NR_BTB_ENTRIES)]
//  BTB_TAG_W       12  tag = pc bits above the BTB index, truncated to BTB_TAG_W
// PORTS
//  clk              in   1     clock, all state on posedge
//  rst              in   1     synchronous reset, active high
//  req_valid        in   1     decode offers a branch/jump for prediction
//  req_ready        out  1     predictor can accept req
//  req_pc           in   XLEN  instruction pc
//  req_id           in   id_t  ROB sequence number
//  req_rvc          in   1     1: 2-byte instruction, fall-through pc+2; else pc+4
//  req_uncond       in   1     JAL/JALR: direction forced taken
//  pred_valid       out  1     prediction available to fetch (same cycle as BQ push)
//  pred_taken       out  1     predicted direction
//  pred_pcnext      out  XLEN  predicted next pc
//  bq_push_io       if   -     bq_push_if.master: valid,ready,bp,pc,id; bqid returned
//  pred_bqid        out  BQID  bqid sampled from bq_push_io at push
//  train_valid      in   1     commit pops a BQ entry
//  train_pc         in   XLEN  pc of committed branch
//  train_taken      in   1     resolved direction
//  train_target     in   XLEN  resolved next pc
//  train_missp      in   1     entry was mispredicted
//  squash_valid     in   1     pipeline squash
// BEHAVIOUR
//  Reset values: req_ready=0, pred_valid=0, bq_push_io.valid=0, pred_taken=0,
//   pred_pcnext=0, pred_bqid=0, state=INIT, init_idx=0.
//  FSM INIT: one BHT entry and one BTB entry cleared per cycle (BHT=2'b01 weakly
//   not-taken, BTB valid=0). init_idx counts 0..max(NR_BHT,NR_BTB)-1; on last index
//   the FSM goes to RUN next cycle. req_ready=0 and training ignored during INIT.
//  rst asserted in any state: outputs return to reset values, restart INIT at idx 0.
//  RUN: lookup is 1 cycle. req accepted when req_valid&&req_ready (edge N);
//   output register (OREG) holds result, bq_push_io.valid=1 from N+1.
//   hit = btb.valid && tag match; taken = req_uncond ? 1 : (bht[1] && hit);
//   pcnext = (taken && hit) ? btb.target : pc + (req_rvc ? 2 : 4); XLEN wrap-around.
//   Uncond miss: taken=1, pcnext=fall-through (BQ resolution flags missp).
//  Handshake: OREG cleared when bq_push_io.valid && bq_push_io.ready.
//   req_ready = (state==RUN) && (!OREG.valid || bq_push_io.ready) && !squash_valid.
//   pred_valid = bq_push_io.valid && bq_push_io.ready (one pulse per prediction).
//   OREG contents stable while valid && !ready.
//  Training (RUN, train_valid): BHT counter saturating +1 if taken, -1 if not (0..3).
//   If train_taken: BTB[idx] <= {valid=1, tag, target}; not-taken leaves BTB unchanged.
//   train_missp is observation-only (perf counter miss_cnt, 32-bit, wraps).
//  Same-cycle lookup and train on same index: lookup uses pre-update table value.
//  squash_valid: OREG.valid <= 0, no push that cycle; tables untouched; priority over
//   req acceptance and push. Squash during INIT has no effect.
// TESTING
//  1. rst 1 cycle -> req_ready=0 for exactly 64 cycles, 1 in cycle 65; no push in INIT.
//  2. Cold req pc=0x1000,rvc=0 -> next cycle push bp.taken=0, pcnext=0x1004; rvc=1 -> 0x1002.
//  3. Train pc=0x1000 taken target=0x2000 twice -> req pc=0x1000 predicts taken, 0x2000;
//     train not-taken twice -> predicts not-taken, pcnext=0x1004.
//  4. Counter saturation: 5 taken trains then 1 not-taken -> still predicts taken.
//  5. bq_push ready=0 for 3 cycles -> push held stable, req_ready=0; ready=1 -> one pulse.
//  6. squash while OREG valid -> no push next cycle; rst mid-INIT -> INIT restarts from 0.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit BHT plus direct-mapped BTB predictor feeding the branch queue
module branch_predictor #(
  parameter int XLEN           = 32,
  parameter int ID_W           = 6,
  parameter int BQID_W         = 4,
  parameter int NR_BHT_ENTRIES = 64,
  parameter int NR_BTB_ENTRIES = 32,
  parameter int BTB_TAG_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_pc,
  input  logic [ID_W-1:0]   req_id,
  input  logic              req_rvc,
  input  logic              req_uncond,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_pcnext,
  output logic              bq_push_valid,
  input  logic              bq_push_ready,
  output logic              bq_push_taken,
  output logic [XLEN-1:0]   bq_push_pcnext,
  output logic [XLEN-1:0]   bq_push_pc,
  output logic [ID_W-1:0]   bq_push_id,
  input  logic [BQID_W-1:0] bq_push_bqid,
  output logic [BQID_W-1:0] pred_bqid,
  input  logic              train_valid,
  input  logic [XLEN-1:0]   train_pc,
  input  logic              train_taken,
  input  logic [XLEN-1:0]   train_target,
  input  logic              train_missp,
  input  logic              squash_valid,
  output logic [31:0]       miss_cnt
);

  localparam int BHT_IW = $clog2(NR_BHT_ENTRIES);
  localparam int BTB_IW = $clog2(NR_BTB_ENTRIES);
  localparam int INIT_N = (NR_BHT_ENTRIES > NR_BTB_ENTRIES) ? NR_BHT_ENTRIES : NR_BTB_ENTRIES;
  localparam int INIT_W = $clog2(INIT_N);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_idx;

  logic [1:0]           bht        [NR_BHT_ENTRIES];
  logic                 btb_valid  [NR_BTB_ENTRIES];
  logic [BTB_TAG_W-1:0] btb_tag    [NR_BTB_ENTRIES];
  logic [XLEN-1:0]      btb_target [NR_BTB_ENTRIES];

  logic                 oreg_valid;
  logic                 oreg_taken;
  logic [XLEN-1:0]      oreg_pcnext;
  logic [XLEN-1:0]      oreg_pc;
  logic [ID_W-1:0]      oreg_id;

  logic [BHT_IW-1:0]    req_bht_idx;
  logic [BTB_IW-1:0]    req_btb_idx;
  logic [BTB_TAG_W-1:0] req_tag;
  logic                 lk_hit;
  logic                 lk_taken;
  logic [XLEN-1:0]      lk_fall;
  logic [XLEN-1:0]      lk_pcnext;

  logic [BHT_IW-1:0]    train_bht_idx;
  logic [BTB_IW-1:0]    train_btb_idx;
  logic [BTB_TAG_W-1:0] train_tag;
  logic [1:0]           train_ctr;
  logic [1:0]           train_ctr_next;

  logic                 push_fire;
  logic                 req_fire;
  logic                 unused_pc_bits;

  // Lookup reads the tables as they stand before this edge's training write
  assign req_bht_idx = req_pc[1 +: BHT_IW];
  assign req_btb_idx = req_pc[1 +: BTB_IW];
  assign req_tag     = req_pc[1 + BTB_IW +: BTB_TAG_W];
  assign lk_hit      = btb_valid[req_btb_idx] && (btb_tag[req_btb_idx] == req_tag);
  assign lk_taken    = req_uncond || (bht[req_bht_idx][1] && lk_hit);
  assign lk_fall     = req_pc + (req_rvc ? XLEN'(2) : XLEN'(4));
  assign lk_pcnext   = (lk_taken && lk_hit) ? btb_target[req_btb_idx] : lk_fall;

  assign train_bht_idx  = train_pc[1 +: BHT_IW];
  assign train_btb_idx  = train_pc[1 +: BTB_IW];
  assign train_tag      = train_pc[1 + BTB_IW +: BTB_TAG_W];
  assign train_ctr      = bht[train_bht_idx];
  assign train_ctr_next = train_taken ? ((train_ctr == 2'd3) ? 2'd3 : train_ctr + 2'd1)
                                      : ((train_ctr == 2'd0) ? 2'd0 : train_ctr - 2'd1);

  // A squash suppresses the push in its own cycle and blocks new requests
  assign bq_push_valid  = oreg_valid && !squash_valid;
  assign push_fire      = bq_push_valid && bq_push_ready;
  assign req_ready      = (state == S_RUN) && (!oreg_valid || bq_push_ready) && !squash_valid;
  assign req_fire       = req_valid && req_ready;
  assign pred_valid     = push_fire;
  assign pred_bqid      = push_fire ? bq_push_bqid : '0;
  assign pred_taken     = oreg_taken;
  assign pred_pcnext    = oreg_pcnext;
  assign bq_push_taken  = oreg_taken;
  assign bq_push_pcnext = oreg_pcnext;
  assign bq_push_pc     = oreg_pc;
  assign bq_push_id     = oreg_id;
  assign unused_pc_bits = ^{req_pc, train_pc};

  // Table storage: swept clean during INIT, trained from commit during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        bht[init_idx[BHT_IW-1:0]]       <= 2'b01;
        btb_valid[init_idx[BTB_IW-1:0]] <= 1'b0;
      end else if (train_valid) begin
        bht[train_bht_idx] <= train_ctr_next;
        if (train_taken) begin
          btb_valid[train_btb_idx]  <= 1'b1;
          btb_tag[train_btb_idx]    <= train_tag;
          btb_target[train_btb_idx] <= train_target;
        end
      end
    end
  end

  // Control FSM, output register and misprediction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      init_idx    <= '0;
      oreg_valid  <= 1'b0;
      oreg_taken  <= 1'b0;
      oreg_pcnext <= '0;
      oreg_pc     <= '0;
      oreg_id     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == INIT_W'(INIT_N - 1)) state <= S_RUN;
        end
        S_RUN: begin
          if (train_valid && train_missp) miss_cnt <= miss_cnt + 32'd1;
          if (squash_valid) begin
            oreg_valid <= 1'b0;
          end else if (req_fire) begin
            oreg_valid  <= 1'b1;
            oreg_taken  <= lk_taken;
            oreg_pcnext <= lk_pcnext;
            oreg_pc     <= req_pc;
            oreg_id     <= req_id;
          end else if (push_fire) begin
            oreg_valid <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rvc, req_uncond;
  logic [31:0] req_pc;
  logic [5:0]  req_id;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_pcnext;
  logic        bq_push_valid, bq_push_ready, bq_push_taken;
  logic [31:0] bq_push_pcnext, bq_push_pc;
  logic [5:0]  bq_push_id;
  logic [3:0]  bq_push_bqid, pred_bqid;
  logic        train_valid, train_taken, train_missp, squash_valid;
  logic [31:0] train_pc, train_target, miss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  int          m_bht [64];
  bit          m_v   [32];
  int unsigned m_tag [32];
  logic [31:0] m_tgt [32];
  int unsigned m_miss;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_id(req_id),
    .req_rvc(req_rvc), .req_uncond(req_uncond),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pcnext(pred_pcnext),
    .bq_push_valid(bq_push_valid), .bq_push_ready(bq_push_ready),
    .bq_push_taken(bq_push_taken), .bq_push_pcnext(bq_push_pcnext),
    .bq_push_pc(bq_push_pc), .bq_push_id(bq_push_id), .bq_push_bqid(bq_push_bqid),
    .pred_bqid(pred_bqid),
    .train_valid(train_valid), .train_pc(train_pc), .train_taken(train_taken),
    .train_target(train_target), .train_missp(train_missp),
    .squash_valid(squash_valid), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 32; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
    m_miss = 0;
  endfunction

  function automatic void model_train(input logic [31:0] pc, input bit tk,
                                      input logic [31:0] tgt, input bit missp);
    int unsigned bi, ti;
    bi = (pc / 2) % 64;
    ti = (pc / 2) % 32;
    if (tk) m_bht[bi] = (m_bht[bi] < 3) ? m_bht[bi] + 1 : 3;
    else    m_bht[bi] = (m_bht[bi] > 0) ? m_bht[bi] - 1 : 0;
    if (tk) begin m_v[ti] = 1; m_tag[ti] = (pc / 64) % 4096; m_tgt[ti] = tgt; end
    if (missp) m_miss = m_miss + 1;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, input bit rvc, input bit unc,
                                     output bit tk, output logic [31:0] nxt);
    int unsigned bi, ti;
    bit hit;
    bi  = (pc / 2) % 64;
    ti  = (pc / 2) % 32;
    hit = m_v[ti] && (m_tag[ti] == (pc / 64) % 4096);
    tk  = unc || ((m_bht[bi] >= 2) && hit);
    nxt = (tk && hit) ? m_tgt[ti] : pc + (rvc ? 32'd2 : 32'd4);
  endfunction

  task automatic count_init(output int n, output int pushes);
    n = 0; pushes = 0;
    req_valid = 1; req_pc = 32'h1000;
    train_valid = 1; train_pc = 32'h1000; train_taken = 1; train_target = 32'h40; train_missp = 1;
    while (n < 200) begin
      squash_valid = (n < 60) && n[0];
      #1;
      if (req_ready) break;
      if (bq_push_valid || pred_valid) pushes++;
      @(posedge clk); #1;
      n++;
    end
    squash_valid = 0; req_valid = 0; train_valid = 0; train_missp = 0;
  endtask

  task automatic do_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit missp);
    train_valid = 1; train_pc = pc; train_taken = tk; train_target = tgt; train_missp = missp;
    @(posedge clk); #1;
    train_valid = 0; train_missp = 0;
    model_train(pc, tk, tgt, missp);
  endtask

  task automatic do_req(input logic [31:0] pc, input bit rvc, input bit unc,
                        input bit tv, input logic [31:0] tpc, input bit ttk, input logic [31:0] ttgt,
                        output bit got, output bit tk, output logic [31:0] nxt,
                        output logic [31:0] opc, output logic [5:0] oid, output logic [3:0] obq);
    int n = 0;
    req_pc = pc; req_rvc = rvc; req_uncond = unc; req_id = 6'($urandom); req_valid = 1;
    bq_push_ready = 1; bq_push_bqid = 4'($urandom);
    #1;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    train_valid = tv; train_pc = tpc; train_taken = ttk; train_target = ttgt; train_missp = 0;
    @(posedge clk); #1;
    req_valid = 0; train_valid = 0;
    #1;
    got = pred_valid; tk = bq_push_taken; nxt = bq_push_pcnext;
    opc = bq_push_pc; oid = bq_push_id; obq = pred_bqid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n, p;
    rst = 1; req_valid = 0; req_pc = 0; req_id = 0; req_rvc = 0; req_uncond = 0;
    bq_push_ready = 1; bq_push_bqid = 0; train_valid = 0; train_pc = 0; train_taken = 0;
    train_target = 0; train_missp = 0; squash_valid = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %0h expected 0", req_ready); end
    n_assert++; if (bq_push_valid !== 1'b0) begin n_fail++; $display("FAIL rst_push_valid: got %0h expected 0", bq_push_valid); end
    n_assert++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pred_valid: got %0h expected 0", pred_valid); end
    n_assert++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken: got %0h expected 0", pred_taken); end
    n_assert++; if (pred_pcnext !== 32'h0) begin n_fail++; $display("FAIL rst_pred_pcnext: got %0h expected 0", pred_pcnext); end
    n_assert++; if (pred_bqid !== 4'h0) begin n_fail++; $display("FAIL rst_pred_bqid: got %0h expected 0", pred_bqid); end
    count_init(n, p);
    n_assert++; if (n !== 64) begin n_fail++; $display("FAIL init_len: got %0d expected 64", n); end
    n_assert++; if (p !== 0) begin n_fail++; $display("FAIL init_push: got %0d expected 0", p); end
    #1;
    n_assert++; if (miss_cnt !== 32'h0) begin n_fail++; $display("FAIL init_train_ignored: got %0h expected 0", miss_cnt); end
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_cold();
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    do_req(32'h1000, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (got !== 1'b1) begin n_fail++; $display("FAIL cold_push: got %0h expected 1", got); end
    n_assert++; if (tk !== 1'b0) begin n_fail++; $display("FAIL cold_taken: got %0h expected 0", tk); end
    n_assert++; if (nxt !== 32'h1004) begin n_fail++; $display("FAIL cold_pcnext4: got %0h expected 1004", nxt); end
    n_assert++; if (opc !== 32'h1000) begin n_fail++; $display("FAIL cold_pc: got %0h expected 1000", opc); end
    n_assert++; if (oid !== req_id) begin n_fail++; $display("FAIL cold_id: got %0h expected %0h", oid, req_id); end
    n_assert++; if (obq !== bq_push_bqid) begin n_fail++; $display("FAIL cold_bqid: got %0h expected %0h", obq, bq_push_bqid); end
    do_req(32'h1000, 1, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (nxt !== 32'h1002) begin n_fail++; $display("FAIL cold_pcnext2: got %0h expected 1002", nxt); end
  endtask

  task automatic test_train();
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    do_train(32'h1000, 1, 32'h2000, 0);
    do_train(32'h1000, 1, 32'h2000, 0);
    do_req(32'h1000, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b1) begin n_fail++; $display("FAIL train_t_taken: got %0h expected 1", tk); end
    n_assert++; if (nxt !== 32'h2000) begin n_fail++; $display("FAIL train_t_pcnext: got %0h expected 2000", nxt); end
    do_train(32'h1000, 0, 32'h1004, 0);
    do_train(32'h1000, 0, 32'h1004, 0);
    do_req(32'h1000, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b0) begin n_fail++; $display("FAIL train_nt_taken: got %0h expected 0", tk); end
    n_assert++; if (nxt !== 32'h1004) begin n_fail++; $display("FAIL train_nt_pcnext: got %0h expected 1004", nxt); end
  endtask

  task automatic test_saturation();
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    for (int i = 0; i < 5; i++) do_train(32'h6010, 1, 32'h6100, 0);
    do_train(32'h6010, 0, 32'h6014, 0);
    do_req(32'h6010, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b1) begin n_fail++; $display("FAIL sat_taken: got %0h expected 1", tk); end
    n_assert++; if (nxt !== 32'h6100) begin n_fail++; $display("FAIL sat_pcnext: got %0h expected 6100", nxt); end
  endtask

  task automatic test_backpressure();
    bit et; logic [31:0] en;
    model_pred(32'h2004, 0, 0, et, en);
    bq_push_ready = 0; req_pc = 32'h2004; req_rvc = 0; req_uncond = 0; req_valid = 1; #1;
    n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_ready: got %0h expected 1", req_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_assert++; if (bq_push_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %0h expected 1", k, bq_push_valid); end
      n_assert++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hold_pred%0d: got %0h expected 0", k, pred_valid); end
      n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready%0d: got %0h expected 0", k, req_ready); end
      n_assert++; if (bq_push_pcnext !== en) begin n_fail++; $display("FAIL bp_hold_pcnext%0d: got %0h expected %0h", k, bq_push_pcnext, en); end
      n_assert++; if (bq_push_taken !== et) begin n_fail++; $display("FAIL bp_hold_taken%0d: got %0h expected %0h", k, bq_push_taken, et); end
      @(posedge clk); #1;
    end
    req_valid = 0; bq_push_ready = 1; bq_push_bqid = 4'h9; #1;
    n_assert++; if (pred_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pulse: got %0h expected 1", pred_valid); end
    n_assert++; if (pred_bqid !== 4'h9) begin n_fail++; $display("FAIL bp_bqid: got %0h expected 9", pred_bqid); end
    @(posedge clk); #1;
    n_assert++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_pulse: got %0h expected 0", pred_valid); end
    n_assert++; if (bq_push_valid !== 1'b0) begin n_fail++; $display("FAIL bp_cleared: got %0h expected 0", bq_push_valid); end
  endtask

  task automatic test_squash();
    bq_push_ready = 0; req_pc = 32'h2006; req_rvc = 0; req_uncond = 0; req_valid = 1; #1;
    @(posedge clk); #1;
    req_pc = 32'h3010; bq_push_ready = 1; squash_valid = 1; #1;
    n_assert++; if (bq_push_valid !== 1'b0) begin n_fail++; $display("FAIL sq_push_valid: got %0h expected 0", bq_push_valid); end
    n_assert++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL sq_pred_valid: got %0h expected 0", pred_valid); end
    n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sq_req_ready: got %0h expected 0", req_ready); end
    @(posedge clk); #1;
    squash_valid = 0; req_valid = 0; #1;
    n_assert++; if (bq_push_valid !== 1'b0) begin n_fail++; $display("FAIL sq_next_push: got %0h expected 0", bq_push_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle();
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    do_train(32'h7002, 1, 32'h7100, 0);
    do_req(32'h7002, 0, 0, 1, 32'h7002, 0, 32'h7006, got, tk, nxt, opc, oid, obq);
    model_train(32'h7002, 0, 32'h7006, 0);
    n_assert++; if (tk !== 1'b1 || nxt !== 32'h7100) begin n_fail++; $display("FAIL same_pre_a: got %0h/%0h expected 1/7100", tk, nxt); end
    do_req(32'h7002, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b0 || nxt !== 32'h7006) begin n_fail++; $display("FAIL same_post_a: got %0h/%0h expected 0/7006", tk, nxt); end
    do_req(32'h700A, 0, 0, 1, 32'h700A, 1, 32'h7200, got, tk, nxt, opc, oid, obq);
    model_train(32'h700A, 1, 32'h7200, 0);
    n_assert++; if (tk !== 1'b0 || nxt !== 32'h700E) begin n_fail++; $display("FAIL same_pre_b: got %0h/%0h expected 0/700e", tk, nxt); end
    do_req(32'h700A, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b1 || nxt !== 32'h7200) begin n_fail++; $display("FAIL same_post_b: got %0h/%0h expected 1/7200", tk, nxt); end
  endtask

  task automatic test_uncond_wrap();
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    do_req(32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (nxt !== 32'h2) begin n_fail++; $display("FAIL wrap4: got %0h expected 2", nxt); end
    do_req(32'hFFFF_FFFE, 1, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (nxt !== 32'h0) begin n_fail++; $display("FAIL wrap2: got %0h expected 0", nxt); end
    do_req(32'h9002, 0, 1, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b1 || nxt !== 32'h9006) begin n_fail++; $display("FAIL uncond_miss: got %0h/%0h expected 1/9006", tk, nxt); end
    do_req(32'h7002, 0, 1, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b1 || nxt !== 32'h7100) begin n_fail++; $display("FAIL uncond_hit: got %0h/%0h expected 1/7100", tk, nxt); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    bit got, tk, et, ttk, rvc, unc, missp;
    logic [31:0] nxt, en, opc, pc, tgt;
    logic [5:0] oid; logic [3:0] obq;
    int op;
    pool = '{32'h1000, 32'h1040, 32'h1080, 32'h2004, 32'h2006, 32'h8000_0100, 32'hFFFF_FFFE, 32'h3010};
    for (int i = 0; i < 120; i++) begin
      op    = $urandom_range(0, 2);
      pc    = pool[$urandom_range(0, 7)];
      ttk   = 1'($urandom);
      tgt   = $urandom & 32'hFFFF_FFFE;
      rvc   = 1'($urandom);
      unc   = ($urandom_range(0, 5) == 0);
      missp = 1'($urandom);
      if (op == 0) begin
        do_train(pc, ttk, tgt, missp);
      end else begin
        model_pred(pc, rvc, unc, et, en);
        do_req(pc, rvc, unc, op == 2, pool[$urandom_range(0, 7)] ^ 32'h0, ttk, tgt,
               got, tk, nxt, opc, oid, obq);
        if (op == 2) model_train(train_pc, ttk, tgt, 0);
        n_assert++; if (got !== 1'b1 || tk !== et || nxt !== en) begin
          n_fail++; $display("FAIL rand_pred%0d pc=%0h: got %0h/%0h/%0h expected 1/%0h/%0h", i, pc, got, tk, nxt, et, en);
        end
      end
    end
    n_assert++; if (miss_cnt !== m_miss) begin n_fail++; $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, m_miss); end
  endtask

  task automatic test_reset_run();
    int n, p;
    do_train(32'h5000, 1, 32'h5500, 0);
    do_train(32'h5000, 1, 32'h5500, 0);
    bq_push_ready = 0; req_pc = 32'h5000; req_rvc = 0; req_uncond = 0; req_valid = 1; #1;
    @(posedge clk); #1;
    req_valid = 0; #1;
    n_assert++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL run_taken: got %0h expected 1", pred_taken); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bq_push_ready = 1; #1;
    n_assert++; if (bq_push_valid !== 1'b0 || pred_taken !== 1'b0 || pred_pcnext !== 32'h0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL run_rst_outputs: got %0h/%0h/%0h/%0h expected 0/0/0/0", bq_push_valid, pred_taken, pred_pcnext, req_ready);
    end
    count_init(n, p);
    n_assert++; if (n !== 64) begin n_fail++; $display("FAIL run_rst_init_len: got %0d expected 64", n); end
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_init();
    int n, p;
    bit got, tk; logic [31:0] nxt, opc; logic [5:0] oid; logic [3:0] obq;
    rst = 1; @(posedge clk); #1; rst = 0;
    repeat (30) @(posedge clk);
    #1; rst = 1; @(posedge clk); #1; rst = 0;
    count_init(n, p);
    n_assert++; if (n !== 64) begin n_fail++; $display("FAIL mid_init_len: got %0d expected 64", n); end
    n_assert++; if (p !== 0) begin n_fail++; $display("FAIL mid_init_push: got %0d expected 0", p); end
    model_reset();
    @(posedge clk); #1;
    do_req(32'h5000, 0, 0, 0, 0, 0, 0, got, tk, nxt, opc, oid, obq);
    n_assert++; if (tk !== 1'b0 || nxt !== 32'h5004) begin n_fail++; $display("FAIL mid_init_cleared: got %0h/%0h expected 0/5004", tk, nxt); end
  endtask

  initial begin
    test_reset();
    test_cold();
    test_train();
    test_saturation();
    test_backpressure();
    test_squash();
    test_same_cycle();
    test_uncond_wrap();
    test_random();
    test_reset_run();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
